matrix_bank: RTL and testbench
==============================

MATRIX_BANK -- requirements
Module: matrix_bank

Interface
REQ-001 Parameter ROWS, default 4, matrix row count (>=1).
REQ-002 Parameter COLS, default 4, matrix column count (>=1).
REQ-003 Parameter EW, default 21, element width in bits; MW = ROWS*COLS*EW (default 336).
REQ-004 Parameter SLOTS, default 4, number of stored matrices (power of two, >=2); SW = log2(SLOTS).
REQ-005 CLK  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 cmd_valid  input  1  command request.
REQ-008 cmd_ready  output  1  block accepts command this cycle.
REQ-009 cmd_op  input  2  00 NOP, 01 LOAD, 10 CLEAR, 11 COPY.
REQ-010 cmd_slot  input  SW  destination slot.
REQ-011 cmd_src  input  SW  source slot (COPY only).
REQ-012 Min  input  MW  load data, element (r,c) at bits [(r*COLS+c)*EW +: EW].
REQ-013 rd_slot  input  SW  read-select.
REQ-014 matrix  output  MW  registered contents of rd_slot.
REQ-015 slot_valid  output  SLOTS  bit k set when slot k holds loaded/copied data.
REQ-016 busy  output  1  multi-cycle CLEAR in progress.

Function
REQ-017 Command accepted on a rising edge where cmd_valid && cmd_ready; cmd_ready = !busy && !reset.
REQ-018 NOP accepted with no state change.
REQ-019 LOAD: slot[cmd_slot] <= Min in the accept cycle; slot_valid[cmd_slot] <= 1.
REQ-020 COPY: slot[cmd_slot] <= slot[cmd_src] in accept cycle; slot_valid[cmd_slot] <= slot_valid[cmd_src]; cmd_src == cmd_slot is a no-op.
REQ-021 CLEAR: FSM IDLE -> CLR; one row (COLS elements) of slot[cmd_slot] zeroed per cycle, row 0 first; ROWS cycles total, then back to IDLE.
REQ-022 slot_valid[cmd_slot] cleared in CLEAR accept cycle; busy high from the cycle after accept for exactly ROWS cycles.
REQ-023 Row counter wraps to 0 on CLR exit; no further commands accepted until IDLE.
REQ-024 Unselected slots hold value (latch) in every cycle.
REQ-025 matrix <= slot[rd_slot] each cycle, 1-cycle latency; read of a slot written in the same cycle returns the pre-write value.
REQ-026 During CLEAR, reads of the slot being cleared return partially cleared contents per REQ-025.
REQ-027 Invalid-slot reads return stored bits regardless of slot_valid.

Reset
REQ-028 reset asserted: all slots, matrix, slot_valid, busy, row counter <= 0; FSM <= IDLE.
REQ-029 reset mid-CLEAR aborts the clear; reset dominates any simultaneous command.
REQ-030 cmd_ready low during reset; high in first cycle after reset deasserts.

Configuration
REQ-031 Macro MATRIX_BANK_ELEM_WR_EN defined: add inputs elem_we (1), elem_slot (SW), elem_row (log2 ROWS, min 1), elem_col (log2 COLS, min 1), elem_data (EW); elem_we writes one element in one cycle, independent of cmd handshake.
REQ-032 With the macro, elem write while busy is ignored; same-cycle LOAD/COPY to the same slot overrides the element write; different slots both take effect; out-of-range row/col ignored; slot_valid unchanged.
REQ-033 Macro undefined: ports absent, no element-write logic.

Verification
REQ-034 Reset, then LOAD slot 2 with Min=pattern(i)=i+1 per element; rd_slot=2 -> matrix equals pattern one cycle later; slot_valid=4'b0100.
REQ-035 LOAD slot 0 = all-ones, COPY 0->3 -> slot 3 all-ones, slot_valid=4'b1001.
REQ-036 CLEAR slot 3 with cmd_valid held high -> busy high 4 cycles, cmd_ready low 4 cycles, next LOAD accepted on cycle 5, slot 3 zero.
REQ-037 Reset asserted on cycle 2 of CLEAR -> all outputs 0, cmd_ready=1 the following cycle.
REQ-038 Same-cycle LOAD slot 1 and rd_slot=1 -> matrix shows old slot 1 then new value next cycle.
REQ-039 (ELEM_WR_EN) elem write (1,2)=21'h1ABCD to slot 0 -> only bits [(1*4+2)*21 +: 21] change; concurrent LOAD slot 0 -> Min wins.

Source files
------------

// File: rtl/matrix_bank.sv
// matrix_bank: SLOTS-deep bank of ROWS x COLS matrices with LOAD, COPY and
// multi-cycle row-by-row CLEAR commands behind a valid/ready handshake.
// Ports: CLK, reset (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_slot/
//   cmd_src/Min command side; rd_slot -> matrix (1-cycle registered read);
//   slot_valid per-slot loaded flag; busy while a CLEAR sweeps its rows.
// Optional: define MATRIX_BANK_ELEM_WR_EN to add the elem_* single-element
//   write port (elem_we, elem_slot, elem_row, elem_col, elem_data).
module matrix_bank #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int EW    = 21,
  parameter int SLOTS = 4
) (
  input  logic                              CLK,
  input  logic                              reset,
`ifdef MATRIX_BANK_ELEM_WR_EN
  input  logic                              elem_we,
  input  logic [$clog2(SLOTS)-1:0]          elem_slot,
  input  logic [((ROWS>1)?$clog2(ROWS):1)-1:0] elem_row,
  input  logic [((COLS>1)?$clog2(COLS):1)-1:0] elem_col,
  input  logic [EW-1:0]                     elem_data,
`endif
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [1:0]                        cmd_op,
  input  logic [$clog2(SLOTS)-1:0]          cmd_slot,
  input  logic [$clog2(SLOTS)-1:0]          cmd_src,
  input  logic [ROWS*COLS*EW-1:0]           Min,
  input  logic [$clog2(SLOTS)-1:0]          rd_slot,
  output logic [ROWS*COLS*EW-1:0]           matrix,
  output logic [SLOTS-1:0]                  slot_valid,
  output logic                              busy
);

  localparam int MW = ROWS * COLS * EW;
  localparam int SW = $clog2(SLOTS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int RB = COLS * EW;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_COPY  = 2'b11;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CLR  = 1'b1;

  logic [MW-1:0] mem [SLOTS];
  logic [0:0]    state;
  logic [RW-1:0] row_cnt;
  logic [SW-1:0] clr_slot;
  logic          accept;

  assign busy      = (state == S_CLR);
  assign cmd_ready = !busy && !reset;
  assign accept    = cmd_valid && cmd_ready;

`ifdef MATRIX_BANK_ELEM_WR_EN
  logic elem_ok;
  int   elem_idx;

  // Element writes land only while idle and only for in-range coordinates.
  always_comb begin
    elem_idx = int'(elem_row) * COLS + int'(elem_col);
    elem_ok  = elem_we && !busy &&
               (int'(elem_row) < ROWS) && (int'(elem_col) < COLS);
  end
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int k = 0; k < SLOTS; k++) begin
        mem[k] <= '0;
      end
      matrix     <= '0;
      slot_valid <= '0;
      state      <= S_IDLE;
      row_cnt    <= '0;
      clr_slot   <= '0;
    end else begin
      // Sampled before this edge's writes: same-cycle writes read old data.
      matrix <= mem[rd_slot];
`ifdef MATRIX_BANK_ELEM_WR_EN
      // Placed ahead of LOAD/COPY so a whole-slot write to the same
      // slot is the later assignment and wins.
      if (elem_ok) begin
        mem[elem_slot][elem_idx*EW +: EW] <= elem_data;
      end
`endif
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            unique case (cmd_op)
              OP_NOP: begin
              end
              OP_LOAD: begin
                mem[cmd_slot]        <= Min;
                slot_valid[cmd_slot] <= 1'b1;
              end
              OP_CLEAR: begin
                slot_valid[cmd_slot] <= 1'b0;
                clr_slot             <= cmd_slot;
                row_cnt              <= '0;
                state                <= S_CLR;
              end
              OP_COPY: begin
                if (cmd_src != cmd_slot) begin
                  mem[cmd_slot]        <= mem[cmd_src];
                  slot_valid[cmd_slot] <= slot_valid[cmd_src];
                end
              end
            endcase
          end
        end
        S_CLR: begin
          mem[clr_slot][int'(row_cnt)*RB +: RB] <= '0;
          if (row_cnt == RW'(ROWS - 1)) begin
            row_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            row_cnt <= row_cnt + RW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_bank.sv
// tb_matrix_bank: directed self-checking bench for matrix_bank (4x4x21, 4 slots).
// Each scenario task drives stimulus and compares inline against hand-built values.
module tb_matrix_bank;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int EW    = 21;
  localparam int SLOTS = 4;
  localparam int MW    = ROWS * COLS * EW;

  logic          CLK = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [1:0]    cmd_slot;
  logic [1:0]    cmd_src;
  logic [MW-1:0] Min;
  logic [1:0]    rd_slot;
  logic [MW-1:0] matrix;
  logic [3:0]    slot_valid;
  logic          busy;
`ifdef MATRIX_BANK_ELEM_WR_EN
  logic          elem_we;
  logic [1:0]    elem_slot;
  logic [1:0]    elem_row;
  logic [1:0]    elem_col;
  logic [EW-1:0] elem_data;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  matrix_bank #(
    .ROWS(ROWS), .COLS(COLS), .EW(EW), .SLOTS(SLOTS)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
`ifdef MATRIX_BANK_ELEM_WR_EN
    .elem_we    (elem_we),
    .elem_slot  (elem_slot),
    .elem_row   (elem_row),
    .elem_col   (elem_col),
    .elem_data  (elem_data),
`endif
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_slot   (cmd_slot),
    .cmd_src    (cmd_src),
    .Min        (Min),
    .rd_slot    (rd_slot),
    .matrix     (matrix),
    .slot_valid (slot_valid),
    .busy       (busy)
  );

  function automatic logic [MW-1:0] pattern();
    logic [MW-1:0] p;
    p = '0;
    for (int i = 0; i < ROWS * COLS; i++) begin
      p[i*EW +: EW] = EW'(i + 1);
    end
    return p;
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [MW-1:0] z;
    z         = '0;
    cmd_slot  = '0;
    cmd_src   = '0;
    Min       = '0;
    rd_slot   = '0;
`ifdef MATRIX_BANK_ELEM_WR_EN
    elem_we   = 1'b0;
    elem_slot = '0;
    elem_row  = '0;
    elem_col  = '0;
    elem_data = '0;
`endif
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    tick();
    tick();
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready_low: got %b want 0", cmd_ready);
    end
    n_cmp++;
    if (matrix !== z) begin
      n_err++;
      $display("FAIL reset_matrix: got %h want 0", matrix);
    end
    n_cmp++;
    if (slot_valid !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_slot_valid: got %b want 0000", slot_valid);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    reset     = 1'b0;
    cmd_valid = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_after: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_load();
    logic [MW-1:0] p;
    p         = pattern();
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_slot  = 2'd2;
    Min       = p;
    rd_slot   = 2'd2;
    tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if (matrix !== '0) begin
      n_err++;
      $display("FAIL load_pre_write: got %h want 0", matrix);
    end
    tick();
    n_cmp++;
    if (matrix !== p) begin
      n_err++;
      $display("FAIL load_data: got %h want %h", matrix, p);
    end
    n_cmp++;
    if (slot_valid !== 4'b0100) begin
      n_err++;
      $display("FAIL load_valid: got %b want 0100", slot_valid);
    end
  endtask

  task automatic test_nop();
    logic [MW-1:0] p;
    p         = pattern();
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_slot  = 2'd2;
    Min       = '0;
    tick();
    cmd_valid = 1'b0;
    tick();
    n_cmp++;
    if (matrix !== p || slot_valid !== 4'b0100) begin
      n_err++;
      $display("FAIL nop_hold: got %b/%h want 0100/%h",
               slot_valid, matrix, p);
    end
  endtask

  task automatic test_copy();
    logic [MW-1:0] ones;
    ones = '1;
    do_reset();
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_slot  = 2'd0;
    Min       = ones;
    tick();
    cmd_op    = 2'b11;
    cmd_slot  = 2'd3;
    cmd_src   = 2'd0;
    tick();
    cmd_op    = 2'b11;
    cmd_slot  = 2'd2;
    cmd_src   = 2'd2;
    tick();
    cmd_valid = 1'b0;
    rd_slot   = 2'd3;
    tick();
    n_cmp++;
    if (matrix !== ones) begin
      n_err++;
      $display("FAIL copy_data: got %h want all ones", matrix);
    end
    n_cmp++;
    if (slot_valid !== 4'b1001) begin
      n_err++;
      $display("FAIL copy_valid: got %b want 1001", slot_valid);
    end
  endtask

  task automatic test_clear();
    logic [MW-1:0] ones;
    logic [MW-1:0] part;
    logic [MW-1:0] p;
    ones = '1;
    part = '1;
    part[COLS*EW-1:0] = '0;
    p = pattern();
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_slot  = 2'd3;
    rd_slot   = 2'd3;
    tick();
    cmd_op    = 2'b01;
    cmd_slot  = 2'd1;
    Min       = p;
    n_cmp++;
    if (slot_valid !== 4'b0001) begin
      n_err++;
      $display("FAIL clear_valid_drop: got %b want 0001", slot_valid);
    end
    for (int i = 0; i < ROWS; i++) begin
      n_cmp++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
        n_err++;
        $display("FAIL clear_busy_%0d: got busy=%b ready=%b want 1/0",
                 i, busy, cmd_ready);
      end
      n_cmp++;
      if (slot_valid !== 4'b0001) begin
        n_err++;
        $display("FAIL clear_no_accept_%0d: got %b want 0001",
                 i, slot_valid);
      end
      if (i == 1) begin
        n_cmp++;
        if (matrix !== ones) begin
          n_err++;
          $display("FAIL clear_read_c1: got %h want all ones", matrix);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (matrix !== part) begin
          n_err++;
          $display("FAIL clear_partial: got %h want %h", matrix, part);
        end
      end
      tick();
    end
    n_cmp++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL clear_done: got busy=%b ready=%b want 0/1",
               busy, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if (slot_valid !== 4'b0011) begin
      n_err++;
      $display("FAIL clear_next_load: got %b want 0011", slot_valid);
    end
    n_cmp++;
    if (matrix !== '0) begin
      n_err++;
      $display("FAIL clear_zero: got %h want 0", matrix);
    end
    rd_slot = 2'd1;
    tick();
    n_cmp++;
    if (matrix !== p) begin
      n_err++;
      $display("FAIL clear_load_data: got %h want %h", matrix, p);
    end
  endtask

  task automatic test_reset_mid_clear();
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_slot  = 2'd1;
    rd_slot   = 2'd0;
    tick();
    cmd_valid = 1'b0;
    tick();
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_slot  = 2'd2;
    Min       = '1;
    tick();
    n_cmp++;
    if (matrix !== '0 || slot_valid !== 4'b0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got m=%h v=%b b=%b want 0/0/0",
               matrix, slot_valid, busy);
    end
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_ready_low: got %b want 0", cmd_ready);
    end
    reset     = 1'b0;
    cmd_valid = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_ready: got %b want 1", cmd_ready);
    end
    rd_slot = 2'd2;
    tick();
    tick();
    n_cmp++;
    if (matrix !== '0 || slot_valid !== 4'b0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_after: got m=%h v=%b b=%b want 0/0/0",
               matrix, slot_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    a = pattern();
    b = ~a;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_slot  = 2'd1;
    Min       = a;
    rd_slot   = 2'd1;
    tick();
    Min = b;
    tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if (matrix !== a) begin
      n_err++;
      $display("FAIL b2b_old: got %h want %h", matrix, a);
    end
    tick();
    n_cmp++;
    if (matrix !== b) begin
      n_err++;
      $display("FAIL b2b_new: got %h want %h", matrix, b);
    end
    n_cmp++;
    if (slot_valid !== 4'b0010) begin
      n_err++;
      $display("FAIL b2b_valid: got %b want 0010", slot_valid);
    end
  endtask

`ifdef MATRIX_BANK_ELEM_WR_EN
  task automatic test_elem();
    logic [MW-1:0] e;
    logic [MW-1:0] p;
    e = '0;
    e[(1*COLS+2)*EW +: EW] = 21'h1ABCD;
    p = pattern();
    do_reset();
    elem_we   = 1'b1;
    elem_slot = 2'd0;
    elem_row  = 2'd1;
    elem_col  = 2'd2;
    elem_data = 21'h1ABCD;
    rd_slot   = 2'd0;
    tick();
    elem_we = 1'b0;
    tick();
    n_cmp++;
    if (matrix !== e || slot_valid !== 4'b0000) begin
      n_err++;
      $display("FAIL elem_write: got %h/%b want %h/0000",
               matrix, slot_valid, e);
    end
    elem_we   = 1'b1;
    elem_data = 21'h00777;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_slot  = 2'd0;
    Min       = p;
    tick();
    elem_we   = 1'b0;
    cmd_valid = 1'b0;
    tick();
    n_cmp++;
    if (matrix !== p) begin
      n_err++;
      $display("FAIL elem_load_wins: got %h want %h", matrix, p);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_nop();
    test_copy();
    test_clear();
    test_reset_mid_clear();
    test_back_to_back();
`ifdef MATRIX_BANK_ELEM_WR_EN
    test_elem();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
